alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Two-requester front end for the shared 16-bit ALU.
- Requester 0 is the execute stage (arithmetic/logic/shift ops). Requester 1 is address generation (LW/SW, opcodes 8/9, though any opcode is legal).
- Arbitrates round-robin, drives the ALU operands and opcode from registered copies, and captures the result, error and flag-set outputs.
- Returns the result on a valid/ready response channel and owns the architectural Z/V/N flag register.

Parameters:
DATA_W, 16, operand/result width
OPC_W, 4, ALU opcode width
ERR_DATA, 16'h0000, rsp_data value returned when the ALU reports an invalid opcode

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  2  per-requester request valid (bit i = requester i)
req_ready  out  2  per-requester accept; at most one bit high
req0_opcode  in  OPC_W  requester 0 opcode
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B
req1_opcode  in  OPC_W  requester 1 opcode
req1_a  in  DATA_W  requester 1 operand A
req1_b  in  DATA_W  requester 1 operand B
alu_in1  out  DATA_W  to ALU operand 1
alu_in2  out  DATA_W  to ALU operand 2
alu_opcode  out  OPC_W  to ALU opcode
alu_out  in  DATA_W  ALU result (combinational from alu_* outputs)
alu_error  in  1  ALU invalid-opcode indication
alu_z_set, alu_v_set, alu_n_set  in  1 each  ALU flag-set outputs
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  requester that owns the response
rsp_data  out  DATA_W  captured result
rsp_err  out  1  captured invalid-opcode error
flag_z, flag_v, flag_n  out  1 each  architectural flag register
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE; alu_in1/alu_in2/alu_opcode=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; flags=0; last_grant=1, so requester 0 wins first.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - winner = requester with req_valid; if both are valid, winner = the one not equal to last_grant.
  - req_ready[winner]=1 combinationally; req_ready=0 in every other state.
  - On handshake: latch opcode/a/b into the alu_* registers, store the id, update last_grant=winner, go to EXEC.
- EXEC (one cycle): ALU settles combinationally. At the clock edge:
  - rsp_data <= alu_error ? ERR_DATA : alu_out.
  - rsp_err <= alu_error.
  - rsp_valid <= 1.
  - Go to RESP.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready: rsp_valid <= 0 and go to IDLE. No new grant is issued in that same cycle.
- Latency: accept at T, response valid at T+2. Minimum issue interval is 3 cycles.
- alu_* outputs hold their last latched values outside EXEC. Requests are not withdrawn once req_valid is high, per requester convention.
- Flag update happens at the EXEC edge, only when id=0 and alu_error=0:
  - Opcodes 0,1 (ADD/SUB): flag_z/v/n <= alu_z_set/v_set/n_set.
  - Opcodes 2,4,5,6 (XOR/SLL/SRA/ROR): flag_z <= alu_z_set only; V and N are retained.
  - All other opcodes, any requester-1 op, and any error: all flags retained.
- Reset in any state: immediate return to reset values. An in-flight response is discarded and never presented.

Optional Feature:
- Macro: ALU_SHARE_ARB_PERF_EN.
- When defined:
  - Adds outputs perf_grant0, perf_grant1 and perf_conflict (16 bits each, reset 0).
  - perf_grant0/perf_grant1 increment on each accepted request of the corresponding requester.
  - perf_conflict increments on each IDLE cycle with req_valid==2'b11.
  - All three saturate at 16'hFFFF.
- When undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Package alu_share_pkg:
  - opcode localparams OPC_ADD=0, OPC_SUB=1, OPC_XOR=2, OPC_RED=3, OPC_SLL=4, OPC_SRA=5, OPC_ROR=6, OPC_PADDSB=7, OPC_LW=8, OPC_SW=9;
  - state encoding IDLE/EXEC/RESP;
  - functions upd_zvn(opc) and upd_z_only(opc).
- Sub-module rr_arb2: 2-way round-robin pick from req_valid and last_grant, producing a one-hot grant.
- The ALU itself stays external.

Test Plan:
- Reset, then req0 ADD a=16'h7FFF b=16'h0001 (ALU saturates): rsp_valid at T+2, rsp_id=0, rsp_data=16'h7FFF, rsp_err=0; flags V=1, N=0, Z=0.
- Both requesters valid in the same cycle after reset (req0 SUB 5-5, req1 LW a=16'h1001 b=16'h0002): req0 granted first with rsp_data=0 and flag_z=1. req1 granted next, with rsp_data=16'h1004 and rsp_id=1; flags unchanged.
- req0 XOR 16'h1234^16'h1234 after the prior ADD left V=1: Z=1, V stays 1, N stays 0.
- req0 opcode 4'hA: rsp_err=1, rsp_data=16'h0000, all flags unchanged.
- Hold rsp_ready=0 for 5 cycles: rsp_valid/data/id/err stable, req_ready=2'b00, busy=1. Then rsp_ready=1 -> IDLE next cycle.
- Assert rst during EXEC: next cycle state=IDLE, rsp_valid=0, flags=0, and no response ever appears. With ALU_SHARE_ARB_PERF_EN defined, also check the counters read 0.

Source files
------------

// File: rtl/alu_share_pkg.sv
// Opcode constants, FSM encoding and flag-update decode shared by the ALU front end.
package alu_share_pkg;

  localparam logic [3:0] OPC_ADD    = 4'd0;
  localparam logic [3:0] OPC_SUB    = 4'd1;
  localparam logic [3:0] OPC_XOR    = 4'd2;
  localparam logic [3:0] OPC_RED    = 4'd3;
  localparam logic [3:0] OPC_SLL    = 4'd4;
  localparam logic [3:0] OPC_SRA    = 4'd5;
  localparam logic [3:0] OPC_ROR    = 4'd6;
  localparam logic [3:0] OPC_PADDSB = 4'd7;
  localparam logic [3:0] OPC_LW     = 4'd8;
  localparam logic [3:0] OPC_SW     = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Ops whose result defines all three architectural flags.
  function automatic logic upd_zvn(input logic [3:0] opc);
    return (opc == OPC_ADD) || (opc == OPC_SUB);
  endfunction

  // Ops that only define Z; V and N keep their previous meaning.
  function automatic logic upd_z_only(input logic [3:0] opc);
    return (opc == OPC_XOR) || (opc == OPC_SLL) ||
           (opc == OPC_SRA) || (opc == OPC_ROR);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational; a lone requester always wins,
// on contention the requester that did not win last time is granted.
module rr_arb2
  import alu_share_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (req_valid == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = req_valid;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin front end for the shared ALU: accept at T, response valid at T+2, held until rsp_ready;
// no new grant until the response retires. Optional perf counters under ALU_SHARE_ARB_PERF_EN.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                OPC_W    = 4,
  parameter logic [DATA_W-1:0] ERR_DATA = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OPC_W-1:0]  req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OPC_W-1:0]  req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [OPC_W-1:0]  alu_opcode,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_error,
  input  logic              alu_z_set,
  input  logic              alu_v_set,
  input  logic              alu_n_set,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n,
`ifdef ALU_SHARE_ARB_PERF_EN
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_conflict,
`endif
  output logic              busy
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] alu_in1_q, alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q, alu_in2_d;
  logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_v_q, flag_v_d;
  logic              flag_n_q, flag_n_d;
  logic [1:0]        grant;
  logic              is_idle;
  logic              accept;

  rr_arb2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign is_idle   = (state_q == IDLE);
  assign req_ready = is_idle ? grant : 2'b00;
  assign accept    = is_idle && (grant != 2'b00);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    alu_opcode_d = alu_opcode_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    flag_z_d     = flag_z_q;
    flag_v_d     = flag_v_q;
    flag_n_d     = flag_n_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (grant[1]) begin
            alu_opcode_d = req1_opcode;
            alu_in1_d    = req1_a;
            alu_in2_d    = req1_b;
          end else begin
            alu_opcode_d = req0_opcode;
            alu_in1_d    = req0_a;
            alu_in2_d    = req0_b;
          end
          id_d         = grant[1];
          last_grant_d = grant[1];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_error ? ERR_DATA : alu_out;
        rsp_err_d   = alu_error;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        // Address-generation traffic and faulting ops never touch the flags.
        if (!id_q && !alu_error) begin
          if (upd_zvn(alu_opcode_q)) begin
            flag_z_d = alu_z_set;
            flag_v_d = alu_v_set;
            flag_n_d = alu_n_set;
          end else if (upd_z_only(alu_opcode_q)) begin
            flag_z_d = alu_z_set;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      alu_opcode_q <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      flag_n_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      alu_opcode_q <= alu_opcode_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      flag_z_q     <= flag_z_d;
      flag_v_q     <= flag_v_d;
      flag_n_q     <= flag_n_d;
    end
  end

  assign alu_in1    = alu_in1_q;
  assign alu_in2    = alu_in2_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign flag_z     = flag_z_q;
  assign flag_v     = flag_v_q;
  assign flag_n     = flag_n_q;
  assign busy       = !is_idle;

`ifdef ALU_SHARE_ARB_PERF_EN
  logic [15:0] perf_grant0_q, perf_grant0_d;
  logic [15:0] perf_grant1_q, perf_grant1_d;
  logic [15:0] perf_conflict_q, perf_conflict_d;

  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_comb begin
    perf_grant0_d   = perf_grant0_q;
    perf_grant1_d   = perf_grant1_q;
    perf_conflict_d = perf_conflict_q;
    if (accept && grant[0] && (perf_grant0_q != 16'hFFFF)) begin
      perf_grant0_d = perf_grant0_q + 16'd1;
    end
    if (accept && grant[1] && (perf_grant1_q != 16'hFFFF)) begin
      perf_grant1_d = perf_grant1_q + 16'd1;
    end
    if (is_idle && (req_valid == 2'b11) && (perf_conflict_q != 16'hFFFF)) begin
      perf_conflict_d = perf_conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0_q   <= '0;
      perf_grant1_q   <= '0;
      perf_conflict_q <= '0;
    end else begin
      perf_grant0_q   <= perf_grant0_d;
      perf_grant1_q   <= perf_grant1_d;
      perf_conflict_q <= perf_conflict_d;
    end
  end

  assign perf_grant0   = perf_grant0_q;
  assign perf_grant1   = perf_grant1_q;
  assign perf_conflict = perf_conflict_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table-driven directed transactions, multi-cycle corner sequences,
// and a randomized run scored against a transaction-level model.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_opcode;
  logic        alu_error, alu_z_set, alu_v_set, alu_n_set;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic        flag_z, flag_v, flag_n, busy;
`ifdef ALU_SHARE_ARB_PERF_EN
  logic [15:0] perf_grant0, perf_grant1, perf_conflict;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_error(alu_error),
    .alu_z_set(alu_z_set), .alu_v_set(alu_v_set), .alu_n_set(alu_n_set),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
`ifdef ALU_SHARE_ARB_PERF_EN
    .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict),
`endif
    .busy(busy)
  );

  // External ALU stand-in. LW/SW form a word address: A rounded to even plus B scaled by 2.
  function automatic void alu_ref(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic err,
                                  output logic z, output logic v, output logic n);
    logic signed [16:0] ss;
    err = 1'b0;
    v   = 1'b0;
    r   = 16'h0000;
    ss  = '0;
    case (op)
      4'd0, 4'd1: begin
        if (op == 4'd0) ss = $signed({a[15], a}) + $signed({b[15], b});
        else            ss = $signed({a[15], a}) - $signed({b[15], b});
        if (ss > 17'sd32767) begin
          r = 16'h7FFF; v = 1'b1;
        end else if (ss < -17'sd32768) begin
          r = 16'h8000; v = 1'b1;
        end else begin
          r = ss[15:0];
        end
      end
      4'd2: r = a ^ b;
      4'd3: r = {15'b0, ^a};
      4'd4: r = a << b[3:0];
      4'd5: r = $signed(a) >>> b[3:0];
      4'd6: r = (a >> b[3:0]) | (a << (16 - {28'b0, b[3:0]}));
      4'd7: r = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
      4'd8, 4'd9: r = {a[15:1], 1'b0} + {b[14:0], 1'b0};
      default: begin
        err = 1'b1;
        r   = 16'hDEAD;
      end
    endcase
    z = (r == 16'h0000);
    n = r[15];
  endfunction

  always_comb begin
    alu_ref(alu_opcode, alu_in1, alu_in2, alu_out, alu_error, alu_z_set, alu_v_set, alu_n_set);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic        id;
    logic [3:0]  opc;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] data;
    logic        err;
    logic        z;
    logic        v;
    logic        n;
  } vec_t;

  vec_t tbl[12];

  task automatic drive_req(input logic id, input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      req1_opcode = opc; req1_a = a; req1_b = b;
    end else begin
      req0_opcode = opc; req0_a = a; req0_b = b;
    end
  endtask

  // Starts and ends just after a rising edge with the DUT idle.
  task automatic run_vec(input int idx, input vec_t v);
    drive_req(v.id, v.opc, v.a, v.b);
    req_valid = v.id ? 2'b10 : 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("vec%0d_rdy", idx), 32'(req_ready), v.id ? 32'h2 : 32'h1);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    chk($sformatf("vec%0d_exec_vld", idx), 32'(rsp_valid), 0);
    cyc();
    @(negedge clk);
    chk($sformatf("vec%0d_vld", idx), 32'(rsp_valid), 1);
    chk($sformatf("vec%0d_id", idx), 32'(rsp_id), 32'(v.id));
    chk($sformatf("vec%0d_data", idx), 32'(rsp_data), 32'(v.data));
    chk($sformatf("vec%0d_err", idx), 32'(rsp_err), 32'(v.err));
    chk($sformatf("vec%0d_flags", idx), 32'({flag_z, flag_v, flag_n}), 32'({v.z, v.v, v.n}));
    cyc();
    @(negedge clk);
    chk($sformatf("vec%0d_idle", idx), 32'(busy), 0);
    cyc();
  endtask

  task automatic run_random(input int ncyc);
    logic [1:0]  pv;
    logic [3:0]  opc[2];
    logic [15:0] ra[2], rb[2];
    logic        free, mlast, w;
    int          age;
    logic [1:0]  exp_rdy;
    logic [15:0] res, e_data;
    logic        err, zs, vs, ns, e_err, e_id, mz, mv, mn;
    logic [3:0]  e_opc;
    int          g0, g1, cf;
    pv = 2'b00; free = 1'b1; mlast = 1'b1; age = 0;
    mz = 1'b0; mv = 1'b0; mn = 1'b0;
    e_data = '0; e_err = 1'b0; e_id = 1'b0; e_opc = '0;
    zs = 1'b0; vs = 1'b0; ns = 1'b0;
    g0 = 0; g1 = 0; cf = 0;
    for (int i = 0; i < 2; i++) begin
      opc[i] = '0; ra[i] = '0; rb[i] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && ($urandom_range(0, 2) == 0)) begin
          pv[i]  = 1'b1;
          opc[i] = 4'($urandom_range(0, 15));
          ra[i]  = 16'($urandom);
          rb[i]  = 16'($urandom);
        end
      end
      drive_req(1'b0, opc[0], ra[0], rb[0]);
      drive_req(1'b1, opc[1], ra[1], rb[1]);
      req_valid = pv;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("rnd_flags", 32'({flag_z, flag_v, flag_n}), 32'({mz, mv, mn}));
      chk("rnd_busy", 32'(busy), 32'(!free));
      if (free) begin
        if (pv == 2'b11) begin
          exp_rdy = mlast ? 2'b01 : 2'b10;
          cf++;
        end else begin
          exp_rdy = pv;
        end
        chk("rnd_rdy", 32'(req_ready), 32'(exp_rdy));
        chk("rnd_idle_vld", 32'(rsp_valid), 0);
        if (exp_rdy != 2'b00) begin
          w = exp_rdy[1];
          alu_ref(opc[w], ra[w], rb[w], res, err, zs, vs, ns);
          e_data = err ? 16'h0000 : res;
          e_err  = err;
          e_id   = w;
          e_opc  = opc[w];
          mlast  = w;
          pv[w]  = 1'b0;
          if (w) g1++; else g0++;
          free = 1'b0;
          age  = 0;
        end
      end else begin
        chk("rnd_busy_rdy", 32'(req_ready), 0);
        age++;
        if (age == 1) begin
          chk("rnd_exec_vld", 32'(rsp_valid), 0);
          if (!e_id && !e_err) begin
            if (e_opc == 4'd0 || e_opc == 4'd1) begin
              mz = zs; mv = vs; mn = ns;
            end else if (e_opc inside {4'd2, 4'd4, 4'd5, 4'd6}) begin
              mz = zs;
            end
          end
        end else begin
          chk("rnd_vld", 32'(rsp_valid), 1);
          chk("rnd_id", 32'(rsp_id), 32'(e_id));
          chk("rnd_data", 32'(rsp_data), 32'(e_data));
          chk("rnd_err", 32'(rsp_err), 32'(e_err));
          if (rsp_ready) free = 1'b1;
        end
      end
      cyc();
    end
`ifdef ALU_SHARE_ARB_PERF_EN
    chk("rnd_perf_g0", 32'(perf_grant0), 32'(g0));
    chk("rnd_perf_g1", 32'(perf_grant1), 32'(g1));
    chk("rnd_perf_conflict", 32'(perf_conflict), 32'(cf));
`else
    if (cf + g0 + g1 < 0) $display("unreachable");
`endif
  endtask

  initial begin
    tbl[0]  = '{1'b0, 4'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'd2, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'hA, 16'h0001, 16'h0002, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'd8, 16'h1001, 16'h0002, 16'h1004, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 4'd0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'd4, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 4'd3, 16'h0007, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'd9, 16'h0010, 16'h0003, 16'h0016, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'd6, 16'h0001, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 4'hF, 16'h0003, 16'h0004, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_opcode = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vld", 32'(rsp_valid), 0);
    chk("rst_rsp", 32'({rsp_id, rsp_err, rsp_data}), 0);
    chk("rst_alu", 32'({alu_opcode, alu_in1}), 0);
    chk("rst_alu2", 32'(alu_in2), 0);
    chk("rst_flags", 32'({flag_z, flag_v, flag_n}), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    cyc();

    // Contention straight after reset: requester 0 first, then requester 1.
    drive_req(1'b0, 4'd1, 16'h0005, 16'h0005);
    drive_req(1'b1, 4'd8, 16'h1001, 16'h0002);
    req_valid = 2'b11; rsp_ready = 1'b1;
    @(negedge clk);
    chk("both_rdy0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b10;
    @(negedge clk);
    chk("both_exec_rdy", 32'(req_ready), 0);
    cyc();
    @(negedge clk);
    chk("both_r0_vld", 32'(rsp_valid), 1);
    chk("both_r0_id", 32'(rsp_id), 0);
    chk("both_r0_data", 32'(rsp_data), 0);
    chk("both_r0_z", 32'(flag_z), 1);
    cyc();
    @(negedge clk);
    chk("both_rdy1", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("both_r1_vld", 32'(rsp_valid), 1);
    chk("both_r1_id", 32'(rsp_id), 1);
    chk("both_r1_data", 32'(rsp_data), 32'h1004);
    chk("both_r1_flags", 32'({flag_z, flag_v, flag_n}), 32'b100);
    cyc();
    @(negedge clk);
    cyc();

    for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

    // Response back-pressure with another request waiting.
    drive_req(1'b0, 4'd1, 16'h0000, 16'h0001);
    req_valid = 2'b01; rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_rdy", 32'(req_ready), 32'h1);
    cyc();
    drive_req(1'b1, 4'd8, 16'h1001, 16'h0002);
    req_valid = 2'b10;
    @(negedge clk);
    chk("hold_exec_vld", 32'(rsp_valid), 0);
    cyc();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_vld", k), 32'(rsp_valid), 1);
      chk($sformatf("hold%0d_data", k), 32'(rsp_data), 32'hFFFF);
      chk($sformatf("hold%0d_id_err", k), 32'({rsp_id, rsp_err}), 0);
      chk($sformatf("hold%0d_rdy", k), 32'(req_ready), 0);
      chk($sformatf("hold%0d_busy", k), 32'(busy), 1);
      cyc();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_rdy", 32'(req_ready), 0);
    cyc();
    @(negedge clk);
    chk("hold_idle_busy", 32'(busy), 0);
    chk("hold_idle_vld", 32'(rsp_valid), 0);
    chk("hold_idle_rdy", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b00;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("hold_r1_data", 32'({rsp_valid, rsp_id, rsp_data}), 32'h31004);
    chk("hold_flags", 32'({flag_z, flag_v, flag_n}), 32'b001);
    cyc();
    @(negedge clk);
    cyc();

    // Reset arriving while an op sits in EXEC.
    drive_req(1'b0, 4'd0, 16'h7FFF, 16'h0001);
    req_valid = 2'b01; rsp_ready = 1'b1;
    @(negedge clk);
    chk("rexec_rdy", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00; rst = 1'b1;
    @(negedge clk);
    chk("rexec_busy", 32'(busy), 1);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rexec_idle", 32'(busy), 0);
    chk("rexec_vld", 32'(rsp_valid), 0);
    chk("rexec_flags", 32'({flag_z, flag_v, flag_n}), 0);
    chk("rexec_alu", 32'({alu_opcode, alu_in1}), 0);
`ifdef ALU_SHARE_ARB_PERF_EN
    chk("rexec_perf", 32'({perf_grant0, perf_grant1}), 0);
    chk("rexec_perf_c", 32'(perf_conflict), 0);
`endif
    for (int k = 0; k < 4; k++) begin
      cyc();
      @(negedge clk);
      chk($sformatf("rexec_quiet%0d", k), 32'(rsp_valid), 0);
    end
    cyc();

    run_random(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
